// File: rtl/bram_port_requester.sv
// bram_port_requester
// Request-side controller for one port of a single-port no-change block RAM.
// Requests are accepted on a valid/ready interface and driven straight to the
// RAM. Reads are tracked through the RAM read latency, and their data lands in
// a small response FIFO. A credit counter guarantees the FIFO never overflows.
// Optional feature macro: BRAM_PORT_REQUESTER_WRITE_ACK_EN. When it is defined,
// writes return an in-order acknowledge with rsp_wr=1 and rsp_rdata=0.
module bram_port_requester #(
   parameter int    RAM_WIDTH       = 18,
   parameter int    RAM_DEPTH       = 1024,
   parameter string RAM_PERFORMANCE = "HIGH_PERFORMANCE",
   parameter int    RSP_DEPTH       = 4,
   localparam int   ADDR_W          = $clog2(RAM_DEPTH)
) (
   input  logic                 clka,
   input  logic                 rsta,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_we,
   input  logic [ADDR_W-1:0]    req_addr,
   input  logic [RAM_WIDTH-1:0] req_wdata,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [RAM_WIDTH-1:0] rsp_rdata,
   output logic                 rsp_wr,
   output logic [ADDR_W-1:0]    ram_addra,
   output logic [RAM_WIDTH-1:0] ram_dina,
   output logic                 ram_wea,
   output logic                 ram_ena,
   output logic                 ram_rsta,
   output logic                 ram_regcea,
   input  logic [RAM_WIDTH-1:0] ram_douta
);
   // The output register adds one cycle of read latency in HIGH_PERFORMANCE mode.
   localparam int LAT = (RAM_PERFORMANCE == "LOW_LATENCY") ? 1 : 2;
   localparam int PW  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int UW  = $clog2(RSP_DEPTH + 1);
   localparam logic [UW-1:0] USED_MAX = UW'(RSP_DEPTH);
   localparam logic [PW-1:0] PTR_LAST = PW'(RSP_DEPTH - 1);

   logic                 accept;
   logic                 credit_ok;
   logic                 credit_take;
   logic                 track_in;
   logic                 push;
   logic                 pop;
   logic [RAM_WIDTH-1:0] push_data;

   logic [LAT-1:0]       trk_vld_q, trk_vld_d;
   logic [UW-1:0]        used_q, used_d;
   logic [UW-1:0]        count_q, count_d;
   logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [RAM_WIDTH-1:0] fifo_data_q [RSP_DEPTH];
   logic [RAM_WIDTH-1:0] fifo_data_d [RSP_DEPTH];
`ifdef BRAM_PORT_REQUESTER_WRITE_ACK_EN
   logic                 push_wr;
   logic [LAT-1:0]       trk_wr_q, trk_wr_d;
   logic [RSP_DEPTH-1:0] fifo_wr_q, fifo_wr_d;
`endif

   // Handshake and credit check; the RAM is driven combinationally from the request.
   always_comb begin
      credit_ok = (used_q < USED_MAX);
`ifdef BRAM_PORT_REQUESTER_WRITE_ACK_EN
      // Every request produces a response, so every request needs a credit.
      req_ready   = !rsta && credit_ok;
      accept      = req_valid && req_ready;
      track_in    = accept;
      credit_take = accept;
`else
      // Writes never produce a response, so they bypass the credit check.
      req_ready   = !rsta && (req_we || credit_ok);
      accept      = req_valid && req_ready;
      track_in    = accept && !req_we;
      credit_take = track_in;
`endif
      ram_ena    = accept;
      ram_wea    = accept && req_we;
      ram_addra  = req_addr;
      ram_dina   = req_wdata;
      ram_regcea = 1'b1;
      ram_rsta   = rsta;
   end

   // Latency tracker: a bit per pipeline stage; the last stage marks valid RAM data.
   always_comb begin
      trk_vld_d    = trk_vld_q;
      trk_vld_d[0] = track_in;
      for (int i = 1; i < LAT; i++) begin
         trk_vld_d[i] = trk_vld_q[i-1];
      end
      push = trk_vld_q[LAT-1];
`ifdef BRAM_PORT_REQUESTER_WRITE_ACK_EN
      trk_wr_d    = trk_wr_q;
      trk_wr_d[0] = accept && req_we;
      for (int i = 1; i < LAT; i++) begin
         trk_wr_d[i] = trk_wr_q[i-1];
      end
      push_wr   = trk_wr_q[LAT-1];
      // The RAM output is stale on a write (no-change mode), so acks carry zero.
      push_data = push_wr ? '0 : ram_douta;
`else
      push_data = ram_douta;
`endif
   end

   // Response side: head of the FIFO straight from registered storage.
   always_comb begin
      rsp_valid = (count_q != '0);
      rsp_rdata = fifo_data_q[rd_ptr_q];
`ifdef BRAM_PORT_REQUESTER_WRITE_ACK_EN
      rsp_wr    = fifo_wr_q[rd_ptr_q];
`else
      rsp_wr    = 1'b0;
`endif
      pop       = rsp_valid && rsp_ready;
   end

   // FIFO pointers, occupancy and credit bookkeeping.
   always_comb begin
      fifo_data_d = fifo_data_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
`ifdef BRAM_PORT_REQUESTER_WRITE_ACK_EN
      fifo_wr_d   = fifo_wr_q;
`endif
      if (push) begin
         fifo_data_d[wr_ptr_q] = push_data;
`ifdef BRAM_PORT_REQUESTER_WRITE_ACK_EN
         fifo_wr_d[wr_ptr_q]   = push_wr;
`endif
         wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
      end
      count_d = count_q + UW'(push) - UW'(pop);
      used_d  = used_q + UW'(credit_take) - UW'(pop);
   end

   // State registers; reset drops everything in flight and empties the FIFO.
   always_ff @(posedge clka) begin
      if (rsta) begin
         trk_vld_q <= '0;
         used_q    <= '0;
         count_q   <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         for (int i = 0; i < RSP_DEPTH; i++) begin
            fifo_data_q[i] <= '0;
         end
      end else begin
         trk_vld_q   <= trk_vld_d;
         used_q      <= used_d;
         count_q     <= count_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         fifo_data_q <= fifo_data_d;
      end
   end

`ifdef BRAM_PORT_REQUESTER_WRITE_ACK_EN
   // Write-ack tags travel alongside the valid bits and FIFO entries.
   always_ff @(posedge clka) begin
      if (rsta) begin
         trk_wr_q  <= '0;
         fifo_wr_q <= '0;
      end else begin
         trk_wr_q  <= trk_wr_d;
         fifo_wr_q <= fifo_wr_d;
      end
   end
`endif

endmodule

// File: tb/tb_bram_port_requester.sv
// Directed testbench for bram_port_requester (default build, L=2, RSP_DEPTH=4).
// Includes a behavioural no-change RAM with output register.
module tb_bram_port_requester;
   logic        clk = 1'b0;
   logic        rsta = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [9:0]  req_addr = '0;
   logic [17:0] req_wdata = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [17:0] rsp_rdata;
   logic        rsp_wr;
   logic [9:0]  ram_addra;
   logic [17:0] ram_dina;
   logic        ram_wea;
   logic        ram_ena;
   logic        ram_rsta;
   logic        ram_regcea;
   logic [17:0] ram_douta;

   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   logic [18:0] exp_q[$];
   int          pop_cyc[$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   bram_port_requester #(
      .RAM_WIDTH(18),
      .RAM_DEPTH(1024),
      .RAM_PERFORMANCE("HIGH_PERFORMANCE"),
      .RSP_DEPTH(4)
   ) dut (
      .clka(clk),
      .rsta(rsta),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_we(req_we),
      .req_addr(req_addr),
      .req_wdata(req_wdata),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata),
      .rsp_wr(rsp_wr),
      .ram_addra(ram_addra),
      .ram_dina(ram_dina),
      .ram_wea(ram_wea),
      .ram_ena(ram_ena),
      .ram_rsta(ram_rsta),
      .ram_regcea(ram_regcea),
      .ram_douta(ram_douta)
   );

   // Behavioural single-port no-change RAM, latency 2 via output register.
   logic [17:0] mem [0:1023];
   logic [17:0] dout1 = '0;
   logic [17:0] dout2 = '0;
   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = '0;
   end
   always @(posedge clk) begin
      if (ram_ena) begin
         if (ram_wea) mem[ram_addra] <= ram_dina;
         else         dout1 <= mem[ram_addra];
      end
      if (ram_rsta)        dout2 <= '0;
      else if (ram_regcea) dout2 <= dout1;
   end
   assign ram_douta = dout2;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
      tests++;
      if (got !== expv) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
      end
   endtask

   // Response monitor: every consumed response must match the next expected one.
   always @(negedge clk) begin
      logic [18:0] e;
      if (!rsta && rsp_valid && rsp_ready) begin
         if (exp_q.size() > 0) e = exp_q.pop_front();
         else                  e = 19'h7FFFF;
         check("rsp", 32'({rsp_wr, rsp_rdata}), 32'(e));
         pop_cyc.push_back(cyc);
         $display("[TB] rsp wr=%0d data=0x%0h cyc=%0d", rsp_wr, rsp_rdata, cyc);
      end
   end

   // Present one request for up to max_wait cycles; record its expected response.
   task automatic send(input logic we, input logic [9:0] a, input logic [17:0] wd,
                       input logic [17:0] rexp, input int max_wait, output logic acc);
      acc = 1'b0;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = a;
      req_wdata = wd;
      for (int k = 0; k < max_wait && !acc; k++) begin
         @(negedge clk);
         if (req_ready) begin
            acc = 1'b1;
`ifdef BRAM_PORT_REQUESTER_WRITE_ACK_EN
            exp_q.push_back(we ? 19'h40000 : {1'b0, rexp});
`else
            if (!we) exp_q.push_back({1'b0, rexp});
`endif
         end
         @(posedge clk); #1;
      end
      $display("[TB] req we=%0d addr=%0d wdata=0x%0h accepted=%0d", we, a, wd, acc);
      req_valid = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 60 && exp_q.size() != 0; k++) begin
         @(posedge clk); #1;
      end
      check("drain_empty", 32'(exp_q.size()), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic       acc;
      logic [5:0] acc_vec;
      int         nacc;
      int         t0;

      // Reset with a pending request: nothing may be accepted or returned.
      @(posedge clk); #1;
      req_valid = 1'b1;
      req_addr  = 10'd7;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_req_ready", 32'(req_ready), 0);
         check("rst_ram_ena",   32'(ram_ena), 0);
         check("rst_ram_wea",   32'(ram_wea), 0);
         check("rst_rsp_valid", 32'(rsp_valid), 0);
         check("rst_rsp_wr",    32'(rsp_wr), 0);
         check("rst_rsp_rdata", 32'(rsp_rdata), 0);
         check("rst_ram_rsta",  32'(ram_rsta), 1);
         @(posedge clk); #1;
      end

      // Release; the write to addr 5 is accepted in the first cycle.
      rsta      = 1'b0;
      req_we    = 1'b1;
      req_addr  = 10'd5;
      req_wdata = 18'h2A5A5;
      @(negedge clk);
      check("first_accept_ready", 32'(req_ready), 1);
      check("wr_ram_ena",   32'(ram_ena), 1);
      check("wr_ram_wea",   32'(ram_wea), 1);
      check("wr_ram_addra", 32'(ram_addra), 5);
      check("wr_ram_dina",  32'(ram_dina), 'h2A5A5);
      check("ram_regcea",   32'(ram_regcea), 1);
`ifdef BRAM_PORT_REQUESTER_WRITE_ACK_EN
      exp_q.push_back(19'h40000);
`endif
      @(posedge clk); #1;

      // Read-after-write in the next cycle.
      req_we = 1'b0;
      @(negedge clk);
      check("raw_rd_ready", 32'(req_ready), 1);
      check("rd_ram_ena",   32'(ram_ena), 1);
      check("rd_ram_wea",   32'(ram_wea), 0);
      exp_q.push_back({1'b0, 18'h2A5A5});
      @(posedge clk); #1;
      req_valid = 1'b0;
`ifndef BRAM_PORT_REQUESTER_WRITE_ACK_EN
      @(negedge clk);
      check("lat_t1_valid", 32'(rsp_valid), 0);
      @(posedge clk); #1;
      @(negedge clk);
      check("lat_t2_valid", 32'(rsp_valid), 0);
      @(posedge clk); #1;
      @(negedge clk);
      check("lat_t3_valid", 32'(rsp_valid), 1);
      check("lat_t3_rdata", 32'(rsp_rdata), 'h2A5A5);
      @(posedge clk); #1;
`endif
      drain();

      // Preload addrs 0..15 with addr+0x100, back-to-back writes.
      for (int i = 0; i < 16; i++) begin
         send(1'b1, 10'(i), 18'('h100 + i), '0, 1, acc);
         check("preload_wr_acc", 32'(acc), 1);
      end
      drain();

      // Streaming reads: one per cycle, never stalled, one response per cycle.
      pop_cyc.delete();
      t0 = cyc;
      for (int i = 0; i < 16; i++) begin
         send(1'b0, 10'(i), '0, 18'('h100 + i), 1, acc);
         check("stream_ready", 32'(acc), 1);
      end
      drain();
      check("stream_count", 32'(pop_cyc.size()), 16);
      if (pop_cyc.size() == 16) begin
         check("stream_span", 32'(pop_cyc[15] - pop_cyc[0]), 15);
         check("stream_first_lat", 32'(pop_cyc[0] - t0), 3);
      end

      // Backpressure: only RSP_DEPTH reads fit while responses are held.
      rsp_ready = 1'b0;
      nacc = 0;
      for (int i = 0; i < 6; i++) begin
         send(1'b0, 10'(i), '0, 18'('h100 + i), 1, acc);
         acc_vec[i] = acc;
         if (acc) nacc++;
      end
      check("bp_accepted", 32'(nacc), 4);
      check("bp_rd4_blocked", 32'(acc_vec[4]), 0);
      check("bp_rd5_blocked", 32'(acc_vec[5]), 0);
`ifndef BRAM_PORT_REQUESTER_WRITE_ACK_EN
      send(1'b1, 10'd30, 18'h3FFFF, '0, 1, acc);
      check("bp_write_ok", 32'(acc), 1);
`endif
      // Release responses: the first pop frees a credit for the next cycle.
      rsp_ready = 1'b1;
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 10'd4;
      @(negedge clk);
      check("bp_full_ready", 32'(req_ready), 0);
      check("bp_full_valid", 32'(rsp_valid), 1);
      @(posedge clk); #1;
      send(1'b0, 10'd4, '0, 18'h104, 1, acc);
      check("bp_rd4_with_pop", 32'(acc), 1);
      send(1'b0, 10'd5, '0, 18'h105, 1, acc);
      check("bp_rd5", 32'(acc), 1);
`ifndef BRAM_PORT_REQUESTER_WRITE_ACK_EN
      send(1'b0, 10'd30, '0, 18'h3FFFF, 8, acc);
      check("bp_rd30", 32'(acc), 1);
`endif
      drain();

      // Reset with two reads in flight and one in the FIFO.
      rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         send(1'b0, 10'(8 + i), '0, 18'('h108 + i), 1, acc);
         check("midrst_pre_acc", 32'(acc), 1);
      end
      rsta = 1'b1;
      @(negedge clk);
      check("midrst_ready", 32'(req_ready), 0);
      check("midrst_fifo_valid", 32'(rsp_valid), 1);
      @(posedge clk); #1;
      rsta = 1'b0;
      exp_q.delete();
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("midrst_no_rsp", 32'(rsp_valid), 0);
         @(posedge clk); #1;
      end
      for (int i = 0; i < 4; i++) begin
         send(1'b0, 10'(i), '0, 18'('h100 + i), 1, acc);
         check("midrst_rd_ok", 32'(acc), 1);
      end
      rsp_ready = 1'b1;
      drain();

      // read(3), write(3,1), read(3): old value, (ack), new value.
      send(1'b0, 10'd3, '0, 18'h103, 2, acc);
      check("seq_rd_old", 32'(acc), 1);
      send(1'b1, 10'd3, 18'h1, '0, 2, acc);
      check("seq_wr", 32'(acc), 1);
      send(1'b0, 10'd3, '0, 18'h1, 2, acc);
      check("seq_rd_new", 32'(acc), 1);
      drain();

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
